bin_decode_skid: RTL and testbench
==================================

BIN_DECODE_SKID -- requirements
Module: bin_decode_skid

Interface
REQ-001 Parameter BIN_W, default 4: width of the binary input code.
REQ-002 Parameter VEC_W, default 16: width of the decoded output vector; legal range 2 <= VEC_W <= 2**BIN_W, with elaboration failing outside it.
REQ-003 Parameter ERR_CNT_W, default 8: width of the error counter.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid_i, input, 1: producer offers bin_i/mode_i this cycle.
REQ-007 Port in_ready_o, output, 1: block can accept an input this cycle.
REQ-008 Port bin_i, input, BIN_W: binary code to decode.
REQ-009 Port mode_i, input, 1: decode mode; 0 selects one-hot, 1 selects thermometer.
REQ-010 Port out_valid_o, output, 1: vec_o/err_o hold a valid result.
REQ-011 Port out_ready_i, input, 1: consumer takes the result this cycle.
REQ-012 Port vec_o, output, VEC_W: decoded vector.
REQ-013 Port err_o, output, 1: the result's input code was out of range (bin_i >= VEC_W).
REQ-014 Port err_cnt_o, output, ERR_CNT_W: saturating count of accepted out-of-range inputs.

Function
REQ-015 An input transfer shall occur on a rising edge where in_valid_i && in_ready_o; an output transfer shall occur where out_valid_o && out_ready_i.
REQ-016 One-hot mode shall produce vec = 1 << bin_i, so exactly one bit is set.
REQ-017 Thermometer mode shall set bits [bin_i:0] and clear all others (bin_i=0 -> only bit 0 set; bin_i=VEC_W-1 -> all ones).
REQ-018 When bin_i >= VEC_W, in either mode, the stored result shall be vec = 0 and err = 1; otherwise err = 0.
REQ-019 Decoding shall happen at acceptance, and the decoded vec/err shall be stored in a 2-entry FIFO.
REQ-020 vec_o/err_o shall always present the oldest stored entry, and results shall leave in acceptance order.
REQ-021 Latency shall be 1 cycle: an input accepted at edge N into an empty buffer shall make out_valid_o=1 after edge N.
REQ-022 Sustained throughput shall be 1 transfer per cycle when out_ready_i=1.
REQ-023 in_ready_o shall be 1 when occupancy < 2, and 0 when occupancy = 2 or reset = 1.
REQ-024 in_ready_o shall not depend combinationally on out_ready_i, so a full buffer popped at edge N accepts no push at edge N.
REQ-025 Occupancy shall change as follows: push only -> +1; pop only -> -1; push and pop together at occupancy 1 -> unchanged, with the new entry becoming head after the pop.
REQ-026 out_valid_o shall be 1 exactly when occupancy > 0.
REQ-027 While out_valid_o=1 and out_ready_i=0, vec_o/err_o shall remain stable.
REQ-028 Inputs presented while in_ready_o=0 shall be ignored and shall not change any state.
REQ-029 err_cnt_o shall increment by 1 for each accepted out-of-range input, and shall saturate at 2**ERR_CNT_W-1 without wrapping.
REQ-030 mode_i shall be sampled per transfer, and mixing modes on consecutive transfers shall be legal.

Reset
REQ-031 On a rising edge with reset=1, the block shall set occupancy=0, out_valid_o=0, vec_o=0, err_o=0 and err_cnt_o=0.
REQ-032 reset shall take priority over any simultaneous push or pop, so buffered entries are discarded and no transfer is counted.
REQ-033 in_ready_o shall be 1 in the first cycle after reset deasserts.

Verification
REQ-034 The bench shall cover the one-hot sweep: with BIN_W=4, VEC_W=16, mode=0, out_ready=1 and bin_i=0..15 back-to-back, vec_o shall be 0x0001..0x8000 one cycle later, one per cycle, with err_o=0.
REQ-035 The bench shall cover thermometer mode: mode=1 with bin_i=0, 3 and 15 shall give vec_o=0x0001, 0x000F and 0xFFFF respectively.
REQ-036 The bench shall cover out of range: with VEC_W=10 and bin_i=12, vec_o shall be 0x000 with err_o=1 and err_cnt_o going 0->1; 300 further bad inputs with ERR_CNT_W=8 shall leave err_cnt_o=255.
REQ-037 The bench shall cover backpressure: with out_ready=0 and bin_i=2 then 5, after 2 accepts in_ready_o=0 and a third input (bin_i=7) shall be ignored; with out_ready=1 the outputs shall be 0x0004 then 0x0020, and in_ready_o shall return to 1.
REQ-038 The bench shall cover simultaneous push and pop: at occupancy 1, push and pop in the same cycle shall leave occupancy at 1 with the new entry at the head the next cycle.
REQ-039 The bench shall cover mid-operation reset: with the buffer full and err_cnt_o=3, asserting reset for 1 cycle shall give out_valid_o=0, err_cnt_o=0 and in_ready_o=1 after deassertion, with no stale result emitted.

Source files
------------

// File: rtl/bin_decode_skid.sv
// Binary-to-vector decoder (one-hot or thermometer) with a 2-entry result FIFO
// and a saturating count of accepted out-of-range codes.
module bin_decode_skid #(
    parameter int BIN_W     = 4,
    parameter int VEC_W     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [BIN_W-1:0]     bin_i,
    input  logic                 mode_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [VEC_W-1:0]     vec_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    if (VEC_W < 2 || VEC_W > (2 ** BIN_W)) begin : g_bad_vec_w
        $error("bin_decode_skid: VEC_W must lie in 2 .. 2**BIN_W");
    end

    localparam logic [BIN_W:0] VEC_LIM = (BIN_W + 1)'(VEC_W);

    logic [VEC_W-1:0]     vec_mem_q [2];
    logic [VEC_W-1:0]     vec_mem_d [2];
    logic                 err_mem_q [2];
    logic                 err_mem_d [2];
    logic                 rd_ptr_q;
    logic                 rd_ptr_d;
    logic [1:0]           count_q;
    logic [1:0]           count_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    logic [VEC_W-1:0]     dec_vec;
    logic                 dec_err;
    logic                 push;
    logic                 pop;
    logic                 wr_idx;

    always_comb begin
        dec_vec = '0;
        dec_err = ({1'b0, bin_i} >= VEC_LIM);
        for (int i = 0; i < VEC_W; i++) begin
            if (mode_i) begin
                dec_vec[i] = ((BIN_W + 1)'(i) <= {1'b0, bin_i});
            end else begin
                dec_vec[i] = ((BIN_W + 1)'(i) == {1'b0, bin_i});
            end
        end
        if (dec_err) begin
            dec_vec = '0;
        end
    end

    // Ready looks only at occupancy, never at out_ready_i.
    assign in_ready_o  = ~count_q[1] & ~reset;
    assign out_valid_o = |count_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign wr_idx      = rd_ptr_q ^ count_q[0];

    assign vec_o     = vec_mem_q[rd_ptr_q];
    assign err_o     = err_mem_q[rd_ptr_q];
    assign err_cnt_o = err_cnt_q;

    always_comb begin
        vec_mem_d = vec_mem_q;
        err_mem_d = err_mem_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        err_cnt_d = err_cnt_q;
        if (push) begin
            vec_mem_d[wr_idx] = dec_vec;
            err_mem_d[wr_idx] = dec_err;
            if (dec_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // Storage is cleared on reset so vec_o/err_o read zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_mem_q[0] <= '0;
            vec_mem_q[1] <= '0;
            err_mem_q[0] <= 1'b0;
            err_mem_q[1] <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            err_cnt_q    <= '0;
        end else begin
            vec_mem_q <= vec_mem_d;
            err_mem_q <= err_mem_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_bin_decode_skid.sv
// Drives a 16-wide and a 10-wide decoder with identical stimulus and compares
// both against a queue-based reference model.
module tb_bin_decode_skid;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] bin;
    logic       mode;
    logic       out_ready;

    logic        iready16, ovalid16, err16;
    logic [15:0] vec16;
    logic [7:0]  ecnt16;
    logic        iready10, ovalid10, err10;
    logic [9:0]  vec10;
    logic [7:0]  ecnt10;

    int checkCount = 0;
    int passCount  = 0;

    logic [4:0] modelQ[$];
    int         expCnt16 = 0;
    int         expCnt10 = 0;

    always #5 clk = ~clk;

    bin_decode_skid #(.BIN_W(4), .VEC_W(16), .ERR_CNT_W(8)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(iready16),
        .bin_i(bin), .mode_i(mode),
        .out_valid_o(ovalid16), .out_ready_i(out_ready),
        .vec_o(vec16), .err_o(err16), .err_cnt_o(ecnt16)
    );

    bin_decode_skid #(.BIN_W(4), .VEC_W(10), .ERR_CNT_W(8)) dut10 (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(iready10),
        .bin_i(bin), .mode_i(mode),
        .out_valid_o(ovalid10), .out_ready_i(out_ready),
        .vec_o(vec10), .err_o(err10), .err_cnt_o(ecnt10)
    );

    function automatic logic [15:0] expVec(int w, logic m, logic [3:0] b);
        int v;
        if (int'(b) >= w) return 16'h0;
        if (!m) v = 1 << b;
        else    v = (1 << (int'(b) + 1)) - 1;
        return 16'(v);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // One clock of stimulus: outputs are checked against the model before the
    // edge, then the model absorbs whatever transfers the edge performs.
    task automatic applyStimulus(input logic v, input logic [3:0] b, input logic m,
                                 input logic ordy, input logic r);
        logic doPush, doPop;
        @(negedge clk);
        in_valid = v; bin = b; mode = m; out_ready = ordy; reset = r;
        #1;
        checkOutput("valid16", ovalid16, modelQ.size() > 0);
        checkOutput("valid10", ovalid10, modelQ.size() > 0);
        checkOutput("ready16", iready16, !r && modelQ.size() < 2);
        checkOutput("ready10", iready10, !r && modelQ.size() < 2);
        if (modelQ.size() > 0) begin
            checkOutput("vec16", vec16, expVec(16, modelQ[0][4], modelQ[0][3:0]));
            checkOutput("err16", err16, 0);
            checkOutput("vec10", vec10, 32'(expVec(10, modelQ[0][4], modelQ[0][3:0])));
            checkOutput("err10", err10, modelQ[0][3:0] >= 4'd10);
        end
        checkOutput("cnt16", ecnt16, expCnt16);
        checkOutput("cnt10", ecnt10, expCnt10);
        doPush = v && !r && modelQ.size() < 2;
        doPop  = !r && modelQ.size() > 0 && ordy;
        @(posedge clk);
        if (r) begin
            modelQ.delete();
            expCnt16 = 0;
            expCnt10 = 0;
        end else begin
            if (doPop) void'(modelQ.pop_front());
            if (doPush) begin
                modelQ.push_back({m, b});
                if (b >= 4'd10 && expCnt10 < 255) expCnt10++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; bin = '0; mode = 1'b0; out_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        #1;
        checkOutput("rst_vec16", vec16, 0);
        checkOutput("rst_err16", err16, 0);
        checkOutput("rst_valid", ovalid16, 0);

        // mid-operation reset with a full buffer and three errors counted
        for (int i = 0; i < 3; i++) applyStimulus(1, 12, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0);
        #1;
        checkOutput("pre_cnt10", ecnt10, 3);
        checkOutput("full_ready", iready16, 0);
        applyStimulus(0, 0, 0, 1, 1);
        #1;
        checkOutput("mid_valid", ovalid16, 0);
        checkOutput("mid_cnt10", ecnt10, 0);
        checkOutput("mid_vec10", vec10, 0);
        reset = 1'b0;
        #1;
        checkOutput("mid_ready", iready16, 1);

        // first out-of-range accept on the 10-wide instance
        applyStimulus(1, 12, 0, 1, 0);
        #1;
        checkOutput("oor_vec10", vec10, 0);
        checkOutput("oor_err10", err10, 1);
        checkOutput("oor_cnt10", ecnt10, 1);
        applyStimulus(0, 0, 0, 1, 0);

        // one-hot sweep
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 4'(i), 0, 1, 0);
            #1;
            checkOutput("sweep", vec16, 32'(1) << i);
        end
        applyStimulus(0, 0, 0, 1, 0);

        // thermometer points
        applyStimulus(1, 0, 1, 1, 0);
        #1; checkOutput("therm0", vec16, 16'h0001);
        applyStimulus(1, 3, 1, 1, 0);
        #1; checkOutput("therm3", vec16, 16'h000F);
        applyStimulus(1, 15, 1, 1, 0);
        #1; checkOutput("therm15", vec16, 16'hFFFF);
        applyStimulus(0, 0, 0, 1, 0);

        // backpressure
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(1, 5, 0, 0, 0);
        #1; checkOutput("bp_ready", iready16, 0);
        applyStimulus(1, 7, 0, 0, 0);
        #1; checkOutput("bp_head", vec16, 16'h0004);
        applyStimulus(0, 0, 0, 1, 0);
        #1; checkOutput("bp_second", vec16, 16'h0020);
        applyStimulus(0, 0, 0, 1, 0);
        #1; checkOutput("bp_ready_back", iready16, 1);

        // simultaneous push and pop at occupancy 1
        applyStimulus(1, 3, 0, 1, 0);
        applyStimulus(1, 9, 0, 1, 0);
        #1;
        checkOutput("pp_valid", ovalid16, 1);
        checkOutput("pp_head", vec16, 16'h0200);
        applyStimulus(0, 0, 0, 1, 0);
        #1; checkOutput("pp_drained", ovalid16, 0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
        end
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);

        // saturation of the error counter
        for (int i = 0; i < 300; i++) applyStimulus(1, 4'(12 + (i % 4)), 1'($urandom), 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        #1; checkOutput("sat_cnt10", ecnt10, 255);
        applyStimulus(0, 0, 0, 1, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
